// File: rtl/dsp_seq_pkg.sv
// ---------------------------------------------------------------------------
// dsp_seq_pkg
// Shared definitions for the dsp_slice control micro-sequencer:
//   - bit positions of the 13-bit instruction word
//   - sequencer state encoding
//   - the registered control-word layout and the NOP word used while draining
// ---------------------------------------------------------------------------
package dsp_seq_pkg;

   // Instruction word layout
   localparam int MUX_LSB  = 0;
   localparam int MUX_W    = 5;
   localparam int NEG_BIT  = 5;
   localparam int LDC_BIT  = 6;
   localparam int ACC_BIT  = 7;
   localparam int COEF_LSB = 8;
   localparam int COEF_W   = 3;
   localparam int CAP_BIT  = 11;
   localparam int LAST_BIT = 12;
   localparam int INSTR_W  = 13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   // Control bundle presented to the slice
   typedef struct packed {
      logic              ena;
      logic              loadconst;
      logic              accumulate;
      logic              negate;
      logic [MUX_W-1:0]  mux_sel;
      logic [COEF_W-1:0] coefsela;
   } ctrl_word_t;

   // Keeps the slice clocking with no operation selected
   localparam ctrl_word_t NOP_WORD = ctrl_word_t'{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0};

endpackage

// File: rtl/dsp_capture_tracker.sv
// ---------------------------------------------------------------------------
// dsp_capture_tracker
// Follows capture flags through the slice pipeline and latches the slice
// result when a flagged word's result emerges.
// Ports:
//   clk, clr        clock, synchronous active-high reset
//   i_shift         advance the tracker this edge (sequencer not idle)
//   i_cap           capture flag of the word being issued this edge
//   i_resulta       slice result
//   o_result_q      last captured result (held between captures)
//   o_result_valid  one-cycle pulse when o_result_q is updated
// ---------------------------------------------------------------------------
module dsp_capture_tracker #(
   parameter int PIPE_LAT = 3
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        i_shift,
   input  logic        i_cap,
   input  logic [63:0] i_resulta,
   output logic [63:0] o_result_q,
   output logic        o_result_valid
);

   logic [PIPE_LAT-1:0] r_pipe;
   logic [63:0]         r_result_q;
   logic                r_result_valid;

   // A flag loaded at edge Ek sits in r_pipe[PIPE_LAT-1] after edge
   // Ek+PIPE_LAT-1, so the capture fires exactly on edge Ek+PIPE_LAT.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_pipe         <= '0;
         r_result_q     <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (i_shift) begin
            r_pipe[0] <= i_cap;
            for (int i = 1; i < PIPE_LAT; i++) begin
               r_pipe[i] <= r_pipe[i-1];
            end
            if (r_pipe[PIPE_LAT-1]) begin
               r_result_q     <= i_resulta;
               r_result_valid <= 1'b1;
            end
         end
      end
   end

   assign o_result_q     = r_result_q;
   assign o_result_valid = r_result_valid;

endmodule

// File: rtl/dsp_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_ctrl_sequencer
// Programmable micro-sequencer for the control side of a dsp_slice.
// A host loads an instruction table while idle, then start runs the program
// rep_count times (0 counts as 1), drains the slice pipeline with NOP words
// for PIPE_LAT cycles and pulses done. Results flagged by the program are
// captured PIPE_LAT edges after their control word was issued.
// Ports:
//   clk, clr                       clock, synchronous active-high reset
//   prog_we/prog_addr/prog_data    table write port (honoured in IDLE only)
//   start, rep_count               run request and pass count
//   busy, done                     status (RUN/DRAIN, end-of-run pulse)
//   ena..coefsela                  registered slice controls
//   resulta                        slice result input
//   result_q, result_valid         captured result and its update strobe
// ---------------------------------------------------------------------------
module dsp_ctrl_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int PIPE_LAT = 3,
   parameter int REP_W    = 8
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic               start,
   input  logic [REP_W-1:0]   rep_count,
   output logic               busy,
   output logic               done,
   output logic               ena,
   output logic               loadconst,
   output logic               accumulate,
   output logic               negate,
   output logic [4:0]         mux_sel,
   output logic [2:0]         coefsela,
   input  logic [63:0]        resulta,
   output logic [63:0]        result_q,
   output logic               result_valid
);

   localparam int DRN_W = $clog2(PIPE_LAT + 1);

   logic [INSTR_W-1:0] r_table [DEPTH];
   seq_state_t         r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [REP_W-1:0]   r_pass;
   logic [DRN_W-1:0]   r_drain;
   ctrl_word_t         r_ctrl;
   logic               r_busy;
   logic               r_done;

   logic [INSTR_W-1:0] w_instr;
   ctrl_word_t         w_word;
   logic               w_end_of_prog;

   // Table has no reset so its contents survive clr
   always_ff @(posedge clk) begin
      if (!clr && prog_we && (r_state == ST_IDLE)) begin
         r_table[prog_addr] <= prog_data;
      end
   end

   assign w_instr       = r_table[r_pc];
   assign w_end_of_prog = w_instr[LAST_BIT] || (r_pc == ADDR_W'(DEPTH - 1));

   always_comb begin
      w_word            = NOP_WORD;
      w_word.loadconst  = w_instr[LDC_BIT];
      w_word.accumulate = w_instr[ACC_BIT];
      w_word.negate     = w_instr[NEG_BIT];
      w_word.mux_sel    = w_instr[MUX_LSB +: MUX_W];
      w_word.coefsela   = w_instr[COEF_LSB +: COEF_W];
   end

   // Outputs are registered from the state held before each edge, so the
   // first instruction appears one edge after the start edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_pass  <= '0;
         r_drain <= '0;
         r_ctrl  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ctrl <= '0;
               r_busy <= 1'b0;
               if (start) begin
                  r_state <= ST_RUN;
                  r_pc    <= '0;
                  r_pass  <= (rep_count == '0) ? REP_W'(1) : rep_count;
               end
            end
            ST_RUN: begin
               r_ctrl <= w_word;
               r_busy <= 1'b1;
               if (w_end_of_prog) begin
                  r_pc <= '0;
                  if (r_pass > REP_W'(1)) begin
                     r_pass <= r_pass - REP_W'(1);
                  end else begin
                     r_state <= ST_DRAIN;
                     r_drain <= DRN_W'(PIPE_LAT);
                  end
               end else begin
                  r_pc <= r_pc + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               r_ctrl  <= NOP_WORD;
               r_busy  <= 1'b1;
               r_drain <= r_drain - DRN_W'(1);
               if (r_drain == DRN_W'(1)) begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_ctrl  <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   dsp_capture_tracker #(
      .PIPE_LAT (PIPE_LAT)
   ) u_tracker (
      .clk            (clk),
      .clr            (clr),
      .i_shift        (r_state != ST_IDLE),
      .i_cap          ((r_state == ST_RUN) && w_instr[CAP_BIT]),
      .i_resulta      (resulta),
      .o_result_q     (result_q),
      .o_result_valid (result_valid)
   );

   assign busy       = r_busy;
   assign done       = r_done;
   assign ena        = r_ctrl.ena;
   assign loadconst  = r_ctrl.loadconst;
   assign accumulate = r_ctrl.accumulate;
   assign negate     = r_ctrl.negate;
   assign mux_sel    = r_ctrl.mux_sel;
   assign coefsela   = r_ctrl.coefsela;

endmodule

// File: tb/tb_dsp_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dsp_ctrl_sequencer
// Expected traffic is derived by expanding the program table into the list
// of issued words (passes x entries up to the last flag), followed by the
// drain NOPs and the done pulse; captures are expected PIPE_LAT edges after
// their word. A small slice model feeds resulta with one fresh value per
// cycle, delayed so the value for a word is present PIPE_LAT edges later.
// ---------------------------------------------------------------------------
module tb_dsp_ctrl_sequencer;

   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 4;
   localparam int PIPE_LAT = 3;
   localparam int REP_W    = 8;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [12:0] prog_data = '0;
   logic        start = 1'b0;
   logic [7:0]  rep_count = '0;
   logic        busy, done, ena, loadconst, accumulate, negate;
   logic [4:0]  mux_sel;
   logic [2:0]  coefsela;
   logic [63:0] resulta = '0;
   logic [63:0] result_q;
   logic        result_valid;

   dsp_ctrl_sequencer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT), .REP_W(REP_W)
   ) dut (
      .clk(clk), .clr(clr), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .rep_count(rep_count),
      .busy(busy), .done(done), .ena(ena), .loadconst(loadconst),
      .accumulate(accumulate), .negate(negate), .mux_sel(mux_sel),
      .coefsela(coefsela), .resulta(resulta), .result_q(result_q),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   // ctrl packing: {ena, loadconst, accumulate, negate, mux_sel[4:0], coefsela[2:0]}
   typedef struct {
      int          cyc;
      logic [11:0] ctrl;
      logic        busy;
      logic        done;
      logic        rv;
      int          src;
   } exp_t;

   exp_t        exp_q[$];
   logic [12:0] tbl [DEPTH];
   logic [63:0] gen [int];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 0;
   bit          fixed_a5 = 0;
   int          rq_clear_at = -1;
   logic [63:0] model_rq = '0;
   logic [63:0] p1 = '0, p2 = '0;

   int          tr_n;
   logic [11:0] tr_ctrl [256];
   logic        tr_busy [256];
   logic        tr_done [256];
   logic        tr_rv   [256];
   logic [63:0] tr_rq   [256];

   function automatic logic [11:0] word_ctrl(input logic [12:0] w);
      return {1'b1, w[6], w[7], w[5], w[4:0], w[10:8]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   // Slice result model plus per-cycle comparison against the expectation queue
   always @(negedge clk) begin : model_cmp
      exp_t e;
      cyc = cyc + 1;
      resulta = p2;
      p2 = p1;
      p1 = fixed_a5 ? 64'hA5 : {$urandom, $urandom};
      gen[cyc] = p1;
      if (chk_en) begin
         e = '{cyc: cyc, ctrl: 12'h000, busy: 1'b0, done: 1'b0, rv: 1'b0, src: 0};
         if (cyc == rq_clear_at) model_rq = '0;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
         if (e.rv) model_rq = gen[e.src];
         chk("ctrl", 64'({ena, loadconst, accumulate, negate, mux_sel, coefsela}), 64'(e.ctrl));
         chk("busy", 64'(busy), 64'(e.busy));
         chk("done", 64'(done), 64'(e.done));
         chk("result_valid", 64'(result_valid), 64'(e.rv));
         chk("result_q", result_q, model_rq);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic write_word(input int a, input logic [12:0] d);
      prog_we = 1'b1;
      prog_addr = 4'(a);
      prog_data = d;
      tick();
      prog_we = 1'b0;
      tbl[a] = d;
   endtask

   // c is the negedge just before the start edge E0
   task automatic build_expect(input int rep, input int c, output int n);
      logic [12:0] words[$];
      exp_t        ev[$];
      int          passes;
      passes = (rep == 0) ? 1 : rep;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            words.push_back(tbl[i]);
            if (tbl[i][12]) break;
         end
      end
      n = words.size();
      for (int j = 0; j < n + PIPE_LAT + 1; j++) begin
         exp_t e;
         e.cyc  = c + 2 + j;
         e.ctrl = (j < n) ? word_ctrl(words[j]) : ((j < n + PIPE_LAT) ? 12'h800 : 12'h000);
         e.busy = (j < n + PIPE_LAT);
         e.done = (j == n + PIPE_LAT);
         e.rv   = 1'b0;
         e.src  = 0;
         ev.push_back(e);
      end
      for (int k = 0; k < n; k++) begin
         if (words[k][11]) begin
            ev[k + PIPE_LAT].rv  = 1'b1;
            ev[k + PIPE_LAT].src = c + 2 + k;
         end
      end
      foreach (ev[j]) exp_q.push_back(ev[j]);
   endtask

   // Called at posedge+2 in IDLE. Trace index i = sample after edge Ei.
   task automatic run_prog(input int rep, input bit noise, input bit abort);
      int n, i, lim;
      bit got;
      build_expect(rep, cyc + 1, n);
      rep_count = 8'(rep);
      start = 1'b1;
      got = 0;
      for (i = 0; i < 3000; i++) begin
         tick();
         if (noise && i >= 1 && i <= n + 1) begin
            start     = 1'($urandom);
            prog_we   = 1'($urandom);
            prog_addr = 4'($urandom);
            prog_data = 13'($urandom);
         end else begin
            start   = 1'b0;
            prog_we = 1'b0;
         end
         if (i < 256) begin
            tr_ctrl[i] = {ena, loadconst, accumulate, negate, mux_sel, coefsela};
            tr_busy[i] = busy;
            tr_done[i] = done;
            tr_rv[i]   = result_valid;
            tr_rq[i]   = result_q;
         end
         if (abort && i == 2) begin
            clr = 1'b1;
            lim = cyc + 2;
            while (exp_q.size() > 0 && exp_q[$].cyc >= lim) void'(exp_q.pop_back());
            rq_clear_at = lim;
            tick();
            clr = 1'b0;
            got = 1;
            break;
         end
         if (done) begin
            got = 1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL run_timeout rep=%0d actual=no_done required=done", rep);
      end
      tr_n = (i < 256) ? i + 1 : 256;
      start = 1'b0;
      prog_we = 1'b0;
      rep_count = '0;
      $display("run rep=%0d noise=%0d abort=%0d words=%0d edges=%0d", rep, noise, abort, n, i);
   endtask

   function automatic int count_ena();
      int c = 0;
      for (int i = 0; i < tr_n; i++) c += int'(tr_ctrl[i][11]);
      return c;
   endfunction

   initial begin
      int bc, rvi, rvn, dni, ng;
      repeat (2) tick();
      chk_en = 1;
      repeat (2) tick();
      clr = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_result_q", result_q, 64'd0);
      for (int a = 0; a < DEPTH; a++) write_word(a, 13'($urandom));

      // Single pass with constant slice result A5
      fixed_a5 = 1;
      write_word(0, 13'h000F);
      write_word(1, 13'h005F);
      write_word(2, 13'h188F);
      repeat (3) tick();
      run_prog(1, 0, 0);
      bc = 0; rvi = -1; dni = -1;
      for (int i = 0; i < tr_n; i++) begin
         bc += int'(tr_busy[i]);
         if (tr_rv[i] && rvi < 0) rvi = i;
         if (tr_done[i] && dni < 0) dni = i;
      end
      chk("sp_busy_cycles", 64'(bc), 64'd6);
      chk("sp_rv_edge", 64'(rvi), 64'd6);
      chk("sp_done_edge", 64'(dni), 64'd7);
      chk("sp_rq", tr_rq[6], 64'hA5);
      chk("sp_word1", 64'(tr_ctrl[2]), 64'hCF8);
      chk("sp_nop", 64'(tr_ctrl[5]), 64'h800);
      fixed_a5 = 0;
      repeat (2) tick();

      // Reset mid-RUN, then rerun from the untouched table
      write_word(0, 13'h0803);
      write_word(1, 13'h0004);
      write_word(2, 13'h0005);
      write_word(3, 13'h1006);
      run_prog(1, 0, 1);
      repeat (8) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      run_prog(1, 0, 0);
      chk("rerun_mux0", 64'(tr_ctrl[1][7:3]), 64'd3);
      chk("rerun_mux3", 64'(tr_ctrl[4][7:3]), 64'd6);

      // Repeat and wrap
      write_word(0, 13'h0007);
      write_word(1, 13'h1029);
      run_prog(3, 0, 0);
      ng = 0;
      for (int i = 0; i < tr_n; i++) ng += int'(tr_ctrl[i][8]);
      chk("rep3_ena", 64'(count_ena()), 64'd9);
      chk("rep3_neg", 64'(ng), 64'd3);
      run_prog(0, 0, 0);
      chk("rep0_ena", 64'(count_ena()), 64'd5);
      for (int a = 0; a < DEPTH; a++) write_word(a, 13'($urandom) & 13'h0FFF);
      run_prog(1, 0, 0);
      chk("nolast_ena", 64'(count_ena()), 64'd19);

      // Ignored start/prog_we while busy, then readback run
      run_prog(2, 1, 0);
      chk("noise_ena", 64'(count_ena()), 64'd35);
      run_prog(1, 0, 0);
      chk("readback_ena", 64'(count_ena()), 64'd19);

      // Back-to-back captures
      write_word(0, 13'h0811);
      write_word(1, 13'h0812);
      write_word(2, 13'h1813);
      run_prog(1, 0, 0);
      rvi = -1; rvn = 0;
      for (int i = 0; i < tr_n; i++) begin
         rvn += int'(tr_rv[i]);
         if (tr_rv[i] && rvi < 0) rvi = i;
      end
      chk("b2b_count", 64'(rvn), 64'd3);
      chk("b2b_first", 64'(rvi), 64'd4);

      // Randomised programs
      for (int t = 0; t < 12; t++) begin
         for (int w = 0; w < 4; w++) begin
            logic [12:0] d;
            d = 13'($urandom);
            d[12] = ($urandom_range(0, 3) == 0);
            write_word($urandom_range(0, DEPTH - 1), d);
         end
         run_prog($urandom_range(0, 3), 1'($urandom), 0);
      end

      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
